ppu_sprite_color_loader: RTL and testbench

PPU front-end loader that fills two register caches from external memories: the 32-byte palette (VRAM 0x3F00–0x3F1F) and a two-entry per-scanline sprite cache (scanned from 256-byte sprite RAM). It sits between the VRAM/SPRAM read ports and the pixel pipeline. Each loader is started by a one-cycle pulse and reports `busy`. The sprite cache also drives live per-pixel "sprite on this column" flags.

---
 rtl/ppu_sprite_color_loader.sv | 210 +++++++++++++++++++++
 tb/tb_ppu_sprite_color_loader.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ppu_sprite_color_loader.sv
// PPU front-end loader: copies the 32-byte palette out of VRAM and scans sprite RAM
// for up to two sprites on the latched scanline, with live per-column hit flags.
module ppu_sprite_color_loader #(
  parameter logic [15:0] PALETTE_BASE  = 16'h3F00,
  parameter int          SPRITE_HEIGHT = 8
) (
  input  logic         clk,
  input  logic         rst,
  output logic [15:0]  vram_read_addr,
  input  logic [7:0]   vram_read_data,
  input  logic         color_start,
  output logic         color_busy,
  output logic [127:0] background_colors,
  output logic [127:0] sprite_colors,
  output logic [7:0]   spram_addr,
  input  logic [7:0]   spram_data_in,
  input  logic [8:0]   curr_row,
  input  logic [8:0]   curr_col,
  output logic         sprite_0_on_tile,
  output logic         sprite_1_on_tile,
  output logic [7:0]   sprite_0_row,
  output logic [7:0]   sprite_0_tile_num,
  output logic [7:0]   sprite_0_attr,
  output logic [7:0]   sprite_0_col,
  output logic [7:0]   sprite_1_row,
  output logic [7:0]   sprite_1_tile_num,
  output logic [7:0]   sprite_1_attr,
  output logic [7:0]   sprite_1_col,
  output logic         sprite_overflow,
  input  logic         sprite_start,
  output logic         sprite_busy,
  input  logic [7:0]   cpu_sprite_addr
);

  localparam logic [9:0] HEIGHT = 10'(SPRITE_HEIGHT);

  typedef enum logic [1:0] {C_IDLE, C_ADDR, C_DATA} color_state_t;
  typedef enum logic [3:0] {
    S_IDLE, S_Y_ADDR, S_Y_DATA, S_T_ADDR, S_T_DATA,
    S_A_ADDR, S_A_DATA, S_X_ADDR, S_X_DATA
  } sprite_state_t;

  color_state_t  c_state, c_next;
  sprite_state_t s_state, s_next;

  logic [4:0] c_idx;
  logic [7:0] palette [32];

  logic [5:0] n;
  logic [8:0] row_lat;
  logic [7:0] base_lat;
  logic       sel;
  logic [1:0] slot_valid;
  logic [7:0] slot_row  [2];
  logic [7:0] slot_tile [2];
  logic [7:0] slot_attr [2];
  logic [7:0] slot_col  [2];
  logic       overflow;
  logic       in_range;
  logic       last_entry;
  logic [1:0] byte_sel;
  logic [1:0] on_tile;

  // Palette loader
  always_comb begin
    c_next = c_state;
    case (c_state)
      C_IDLE:  if (color_start) c_next = C_ADDR;
      C_ADDR:  c_next = C_DATA;
      C_DATA:  c_next = (c_idx == 5'd31) ? C_IDLE : C_ADDR;
      default: c_next = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_state <= C_IDLE;
      c_idx   <= '0;
      for (int i = 0; i < 32; i++) palette[i] <= '0;
    end else begin
      c_state <= c_next;
      if (c_state == C_IDLE && color_start) c_idx <= '0;
      if (c_state == C_DATA) begin
        palette[c_idx] <= vram_read_data;
        c_idx          <= c_idx + 5'd1;
      end
    end
  end

  assign color_busy     = (c_state != C_IDLE);
  assign vram_read_addr = (c_state == C_IDLE) ? 16'h0000 : PALETTE_BASE + {11'b0, c_idx};

  always_comb begin
    background_colors = '0;
    sprite_colors     = '0;
    for (int k = 0; k < 16; k++) begin
      background_colors[8*k +: 8] = palette[k];
      sprite_colors[8*k +: 8]     = palette[16+k];
    end
  end

  // Sprite scanner: 10-bit compares so Y+height never wraps past 255
  assign in_range   = ({2'b00, spram_data_in} <= {1'b0, row_lat}) &&
                      ({1'b0, row_lat} < {2'b00, spram_data_in} + HEIGHT);
  assign last_entry = (n == 6'd63);

  always_comb begin
    byte_sel = 2'd0;
    case (s_state)
      S_T_ADDR, S_T_DATA: byte_sel = 2'd1;
      S_A_ADDR, S_A_DATA: byte_sel = 2'd2;
      S_X_ADDR, S_X_DATA: byte_sel = 2'd3;
      default:            byte_sel = 2'd0;
    endcase
  end

  assign spram_addr = (s_state == S_IDLE) ? 8'h00 : base_lat + {n, 2'b00} + {6'b0, byte_sel};

  always_comb begin
    s_next = s_state;
    case (s_state)
      S_IDLE:   if (sprite_start) s_next = S_Y_ADDR;
      S_Y_ADDR: s_next = S_Y_DATA;
      S_Y_DATA: begin
        if (!in_range)        s_next = last_entry ? S_IDLE : S_Y_ADDR;
        else if (&slot_valid) s_next = S_IDLE;
        else                  s_next = S_T_ADDR;
      end
      S_T_ADDR: s_next = S_T_DATA;
      S_T_DATA: s_next = S_A_ADDR;
      S_A_ADDR: s_next = S_A_DATA;
      S_A_DATA: s_next = S_X_ADDR;
      S_X_ADDR: s_next = S_X_DATA;
      S_X_DATA: s_next = last_entry ? S_IDLE : S_Y_ADDR;
      default:  s_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_state    <= S_IDLE;
      n          <= '0;
      row_lat    <= '0;
      base_lat   <= '0;
      sel        <= 1'b0;
      slot_valid <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        slot_row[i]  <= 8'hFF;
        slot_tile[i] <= 8'hFF;
        slot_attr[i] <= 8'hFF;
        slot_col[i]  <= 8'hFF;
      end
    end else begin
      s_state <= s_next;
      case (s_state)
        S_IDLE: if (sprite_start) begin
          row_lat    <= curr_row;
          base_lat   <= cpu_sprite_addr;
          n          <= '0;
          slot_valid <= '0;
          overflow   <= 1'b0;
          for (int i = 0; i < 2; i++) begin
            slot_row[i]  <= 8'hFF;
            slot_tile[i] <= 8'hFF;
            slot_attr[i] <= 8'hFF;
            slot_col[i]  <= 8'hFF;
          end
        end
        S_Y_DATA: begin
          if (!in_range) n <= n + 6'd1;
          else if (&slot_valid) overflow <= 1'b1;
          else begin
            sel                    <= slot_valid[0];
            slot_row[slot_valid[0]] <= spram_data_in;
          end
        end
        S_T_DATA: slot_tile[sel] <= spram_data_in;
        S_A_DATA: slot_attr[sel] <= spram_data_in;
        S_X_DATA: begin
          slot_col[sel]   <= spram_data_in;
          slot_valid[sel] <= 1'b1;
          n               <= n + 6'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++)
      on_tile[i] = slot_valid[i] &&
                   ({2'b00, slot_col[i]} <= {1'b0, curr_col}) &&
                   ({1'b0, curr_col} < {2'b00, slot_col[i]} + HEIGHT);
  end

  assign sprite_busy       = (s_state != S_IDLE);
  assign sprite_overflow   = overflow;
  assign sprite_0_on_tile  = on_tile[0];
  assign sprite_1_on_tile  = on_tile[1];
  assign sprite_0_row      = slot_row[0];
  assign sprite_0_tile_num = slot_tile[0];
  assign sprite_0_attr     = slot_attr[0];
  assign sprite_0_col      = slot_col[0];
  assign sprite_1_row      = slot_row[1];
  assign sprite_1_tile_num = slot_tile[1];
  assign sprite_1_attr     = slot_attr[1];
  assign sprite_1_col      = slot_col[1];

endmodule

// File: tb/tb_ppu_sprite_color_loader.sv
// Directed bench for ppu_sprite_color_loader with synchronous-read VRAM/SPRAM models.
module tb_ppu_sprite_color_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  vram_read_addr;
  logic [7:0]   vram_read_data;
  logic         color_start;
  logic         color_busy;
  logic [127:0] background_colors;
  logic [127:0] sprite_colors;
  logic [7:0]   spram_addr;
  logic [7:0]   spram_data_in;
  logic [8:0]   curr_row;
  logic [8:0]   curr_col;
  logic         sprite_0_on_tile, sprite_1_on_tile;
  logic [7:0]   sprite_0_row, sprite_0_tile_num, sprite_0_attr, sprite_0_col;
  logic [7:0]   sprite_1_row, sprite_1_tile_num, sprite_1_attr, sprite_1_col;
  logic         sprite_overflow;
  logic         sprite_start;
  logic         sprite_busy;
  logic [7:0]   cpu_sprite_addr;

  logic [7:0] pal_mem [32];
  logic [7:0] spram   [256];
  int total = 0;
  int bad   = 0;
  int cyc;

  ppu_sprite_color_loader dut (
    .clk(clk), .rst(rst),
    .vram_read_addr(vram_read_addr), .vram_read_data(vram_read_data),
    .color_start(color_start), .color_busy(color_busy),
    .background_colors(background_colors), .sprite_colors(sprite_colors),
    .spram_addr(spram_addr), .spram_data_in(spram_data_in),
    .curr_row(curr_row), .curr_col(curr_col),
    .sprite_0_on_tile(sprite_0_on_tile), .sprite_1_on_tile(sprite_1_on_tile),
    .sprite_0_row(sprite_0_row), .sprite_0_tile_num(sprite_0_tile_num),
    .sprite_0_attr(sprite_0_attr), .sprite_0_col(sprite_0_col),
    .sprite_1_row(sprite_1_row), .sprite_1_tile_num(sprite_1_tile_num),
    .sprite_1_attr(sprite_1_attr), .sprite_1_col(sprite_1_col),
    .sprite_overflow(sprite_overflow), .sprite_start(sprite_start),
    .sprite_busy(sprite_busy), .cpu_sprite_addr(cpu_sprite_addr)
  );

  always #5 clk = ~clk;

  // Memories return data the cycle after the address
  always @(posedge clk) begin
    vram_read_data <= (vram_read_addr[15:5] == 11'h1F8) ? pal_mem[vram_read_addr[4:0]] : 8'h00;
    spram_data_in  <= spram[spram_addr];
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse a start (0 = color, 1 = sprite) and count busy cycles, bounded.
  task automatic run_load(input int which, output int cycles);
    @(negedge clk);
    if (which == 0) color_start = 1'b1; else sprite_start = 1'b1;
    @(negedge clk);
    color_start  = 1'b0;
    sprite_start = 1'b0;
    cycles = 0;
    while (((which == 0) ? color_busy : sprite_busy) && cycles < 1000) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic chk_slots_empty(input string tag);
    chk({tag, "_slot0"}, {sprite_0_row, sprite_0_tile_num, sprite_0_attr, sprite_0_col}, 32'hFFFF_FFFF);
    chk({tag, "_slot1"}, {sprite_1_row, sprite_1_tile_num, sprite_1_attr, sprite_1_col}, 32'hFFFF_FFFF);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin
      if (k < 10)      pal_mem[k] = 8'(k);
      else if (k < 20) pal_mem[k] = 8'(8'h10 + k - 10);
      else if (k < 30) pal_mem[k] = 8'(8'h20 + k - 20);
      else             pal_mem[k] = 8'(8'h30 + k - 30);
    end
    // 8 sprites at Y=0, tile=n, attr=0x1F, X=8n; the rest parked at Y=0xF0
    for (int i = 0; i < 256; i++) begin
      if (i < 32) begin
        case (i % 4)
          0: spram[i] = 8'h00;
          1: spram[i] = 8'(i / 4);
          2: spram[i] = 8'h1F;
          default: spram[i] = 8'(8 * (i / 4));
        endcase
      end else spram[i] = 8'hF0;
    end

    rst = 1'b1; color_start = 1'b0; sprite_start = 1'b0;
    curr_row = '0; curr_col = '0; cpu_sprite_addr = '0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_color_busy", color_busy, 0);
    chk("rst_sprite_busy", sprite_busy, 0);
    chk("rst_bg", background_colors, 0);
    chk("rst_spr_pal", sprite_colors, 0);
    chk_slots_empty("rst");
    chk("rst_on_tile", {sprite_0_on_tile, sprite_1_on_tile}, 0);
    chk("rst_overflow", sprite_overflow, 0);
    rst = 1'b0;

    // Palette load
    run_load(0, cyc);
    chk("color_busy_cycles", cyc, 64);
    chk("bg_byte0", background_colors[7:0], 8'h00);
    chk("bg_byte10", background_colors[87:80], 8'h10);
    chk("bg_byte15", background_colors[127:120], 8'h15);
    chk("spr_pal_byte0", sprite_colors[7:0], 8'h16);
    chk("spr_pal_byte15", sprite_colors[127:120], 8'h31);

    // Overflow scan from OAM 0 on row 5
    curr_row = 9'd5; cpu_sprite_addr = 8'h00;
    run_load(1, cyc);
    chk("ovf_busy_cycles", cyc, 18);
    chk("ovf_slot0", {sprite_0_row, sprite_0_tile_num, sprite_0_attr, sprite_0_col}, 32'h00001F00);
    chk("ovf_slot1", {sprite_1_row, sprite_1_tile_num, sprite_1_attr, sprite_1_col}, 32'h00011F08);
    chk("ovf_flag", sprite_overflow, 1);

    // Column hit flags follow curr_col combinationally
    curr_col = 9'd5;  #1;
    chk("on_tile_col5", {sprite_0_on_tile, sprite_1_on_tile}, 2'b10);
    curr_col = 9'd9;  #1;
    chk("on_tile_col9", {sprite_0_on_tile, sprite_1_on_tile}, 2'b01);
    curr_col = 9'd17; #1;
    chk("on_tile_col17", {sprite_0_on_tile, sprite_1_on_tile}, 2'b00);
    curr_col = 9'd7;  #1;
    chk("on_tile_col7", {sprite_0_on_tile, sprite_1_on_tile}, 2'b10);
    curr_col = 9'd15; #1;
    chk("on_tile_col15", {sprite_0_on_tile, sprite_1_on_tile}, 2'b01);
    curr_col = 9'd16; #1;
    chk("on_tile_col16", {sprite_0_on_tile, sprite_1_on_tile}, 2'b00);

    // Row 8 is one past the Y=0 sprites' last line: full 64-entry miss scan
    curr_row = 9'd8;
    run_load(1, cyc);
    chk("miss_busy_cycles", cyc, 128);
    chk_slots_empty("miss");
    chk("miss_overflow", sprite_overflow, 0);
    curr_col = 9'd0; #1;
    chk("miss_on_tile", {sprite_0_on_tile, sprite_1_on_tile}, 2'b00);

    // Scan starting at OAM byte 8 (sprite 2); row changed after start has no effect
    curr_row = 9'd5; cpu_sprite_addr = 8'h08;
    @(negedge clk);
    sprite_start = 1'b1;
    @(negedge clk);
    sprite_start = 1'b0;
    curr_row = 9'd100;
    cyc = 0;
    while (sprite_busy && cyc < 1000) begin
      cyc++;
      @(negedge clk);
    end
    chk("off_busy_cycles", cyc, 18);
    chk("off_slot0", {sprite_0_tile_num, sprite_0_col}, 16'h0210);
    chk("off_slot1", {sprite_1_tile_num, sprite_1_col}, 16'h0318);
    chk("off_overflow", sprite_overflow, 1);
    chk("palette_held", sprite_colors[127:120], 8'h31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
